branch_check_queue: RTL and testbench
=====================================

Name: branch_check_queue

Overview:
- Sits downstream of the branch predictor. Records every prediction issued at IF (pdPC, pdBranch, pdReason) per fetched instruction pair, in program order.
- When EX resolves instructions, compares the actual outcome against the oldest recorded prediction and produces the exWrong/redirect signals that the predictor and the PC generator consume.
- Flushes its own contents on a mispredict or on an external flush.

Parameters:
- ADDR_WIDTH, 32, address width.
- QUEUE_DEPTH, 8, entry count; must be a power of 2, at least 2.
- PTR_WIDTH, 3, log2(QUEUE_DEPTH).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- pushVld  in  1  IF pushes one prediction entry this cycle
- pushRdy  out  1  queue can accept a push (count < QUEUE_DEPTH)
- pushPC  in  ADDR_WIDTH  PC of fetched pair (slot0 = pushPC, slot1 = pushPC+4)
- pushPdPC  in  ADDR_WIDTH  predicted next PC
- pushPdBranch  in  1  branch predicted
- pushPdReason  in  1  slot causing predicted branch (0/1)
- exVld  in  1  EX resolves one instruction
- exSlot  in  1  slot of resolved instruction within oldest entry
- exLast  in  1  last instruction of oldest entry; pop after check
- exBranch  in  1  instruction actually branched
- exPCTar  in  ADDR_WIDTH  actual target
- flush  in  1  external flush (exception/ertn)
- chkWrong  out  1  mispredict detected (registered)
- chkPC  out  ADDR_WIDTH  correct next PC (registered)
- qEmpty  out  1  count == 0

Behaviour:
- Reset clears head, tail and count to 0 and entries to 0. Output reset values: chkWrong=0, chkPC=0, qEmpty=1, pushRdy=1.
- Storage: circular buffer of {pc, pdPC, pdBranch, pdReason}.
  - head = oldest entry, tail = next write; both wrap modulo QUEUE_DEPTH.
  - count has PTR_WIDTH+1 bits.
- Push: accepted when pushVld & pushRdy. pushRdy depends on count only; a pop in the same cycle does not free a slot for a push when the queue is full.
- Check, evaluated against the head entry when exVld and the queue is non-empty. Let ipc = pc + 4*exSlot.
  - If pdBranch and pdReason==exSlot: wrong = ~exBranch | (exPCTar != pdPC).
  - If pdBranch and pdReason > exSlot: wrong = exBranch.
  - If ~pdBranch: wrong = exBranch.
  - Correct PC = exBranch ? exPCTar : ipc+4 (ADDR_WIDTH wrap).
- Latency: chkWrong/chkPC are registered one cycle after exVld. chkWrong is a 1-cycle pulse; chkPC holds its value until the next mispredict.
- Mispredict: on the following edge, clear count/head/tail (full flush). Any push in that same cycle is dropped, and the pop is irrelevant.
- External flush: clears the queue on the next edge, drops any same-cycle push, and suppresses chkWrong in that cycle. Flush has priority over mispredict.
- Pop: on exVld & exLast & ~wrong & ~flush, head advances by 1.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- exVld while empty: ignored; no output pulse and no state change.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro BRQ_STAT_EN.
  - Defined: adds outputs statTotal and statWrong (32-bit each). They count resolved checks and mispredicts, saturate at all-ones, are cleared on reset only, and are unaffected by flush.
  - Undefined: these ports and counters do not exist and the logic is identical otherwise.

Decomposition:
- Shared package/header holds:
  - the entry field widths and bit offsets (pc, pdPC, pdBranch, pdReason), packed;
  - INST_BYTES=4 and SLOT_NUM=2.
- One sub-module, brq_checker: purely combinational compare of the head entry against the EX outcome, producing wrong and correctPC. The queue wrapper owns the pointers, count and output registers.

Test Plan:
- Push {pc=0x1000, pdBranch=0}; EX slot0 exBranch=0 exLast=0, then slot1 exBranch=0 exLast=1 -> chkWrong stays 0, qEmpty=1 afterwards.
- Push {pc=0x1000, pdBranch=1, reason=1, pdPC=0x2000}; EX slot1 exBranch=1 exPCTar=0x2400 -> next cycle chkWrong=1, chkPC=0x2400, queue empty.
- Push same entry; EX slot0 exBranch=0 then slot1 exBranch=0 exLast=1 -> on the slot1 check chkWrong=1, chkPC=0x1008.
- Push 8 entries -> pushRdy=0; push + pop in the same cycle -> push rejected, count=7; next push accepted, and tail wraps to index 0.
- With 3 entries queued, assert flush together with pushVld and a mispredicting exVld -> no chkWrong pulse, queue empty, push dropped.
- Assert rstn=0 mid-stream with 5 entries -> asynchronous clear, qEmpty=1, chkWrong=0; with BRQ_STAT_EN also check statTotal and statWrong after 3 checks with 1 mispredict = 3/1.

Source files
------------

// File: rtl/branch_check_queue_pkg.sv
// Shared definitions for the branch check queue: instruction geometry and
// the packed layout of one queue entry {pdReason, pdBranch, pdPC, pc}.
package branch_check_queue_pkg;

  localparam int INST_BYTES = 4;
  localparam int SLOT_NUM   = 2;

  // Field widths of a queue entry, given the address width
  localparam int PDBR_W  = 1;
  localparam int PDRSN_W = 1;

  // Bit offsets of each field inside a packed entry
  localparam int PC_LSB = 0;

  function automatic int pdpc_lsb(input int aw);
    return PC_LSB + aw;
  endfunction

  function automatic int pdbr_bit(input int aw);
    return pdpc_lsb(aw) + aw;
  endfunction

  function automatic int pdrsn_bit(input int aw);
    return pdbr_bit(aw) + PDBR_W;
  endfunction

  function automatic int entry_width(input int aw);
    return pdrsn_bit(aw) + PDRSN_W;
  endfunction

endpackage

// File: rtl/branch_check_queue_checker.sv
// brq_checker: combinational compare of the oldest recorded prediction
// against the outcome EX resolved, giving the mispredict flag and the
// PC execution must continue from.
module brq_checker
  import branch_check_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]        pc,
  input  logic [ADDR_WIDTH-1:0]        pd_pc,
  input  logic                         pd_branch,
  input  logic                         pd_reason,
  input  logic [$clog2(SLOT_NUM)-1:0]  ex_slot,
  input  logic                         ex_branch,
  input  logic [ADDR_WIDTH-1:0]        ex_pc_tar,
  output logic                         wrong,
  output logic [ADDR_WIDTH-1:0]        correct_pc
);

  logic [ADDR_WIDTH-1:0] ipc;

  // A slot that was not the predicted-taken one is wrong only if it branched;
  // the predicted slot must branch and hit the predicted target.
  always_comb begin
    wrong = ex_branch;
    if (pd_branch && (pd_reason == ex_slot))
      wrong = ~ex_branch | (ex_pc_tar != pd_pc);
    ipc        = pc + ADDR_WIDTH'(INST_BYTES) * ADDR_WIDTH'(ex_slot);
    correct_pc = ex_branch ? ex_pc_tar : ipc + ADDR_WIDTH'(INST_BYTES);
  end

endmodule

// File: rtl/branch_check_queue.sv
// branch_check_queue: in-order record of IF predictions, checked against EX
// resolution; raises a one-cycle chkWrong with the correct PC on mispredict.
// Optional build macro BRQ_STAT_EN adds saturating statTotal/statWrong counters.
module branch_check_queue
  import branch_check_queue_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 8,
  parameter int PTR_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pushVld,
  output logic                  pushRdy,
  input  logic [ADDR_WIDTH-1:0] pushPC,
  input  logic [ADDR_WIDTH-1:0] pushPdPC,
  input  logic                  pushPdBranch,
  input  logic                  pushPdReason,
  input  logic                  exVld,
  input  logic                  exSlot,
  input  logic                  exLast,
  input  logic                  exBranch,
  input  logic [ADDR_WIDTH-1:0] exPCTar,
  input  logic                  flush,
  output logic                  chkWrong,
  output logic [ADDR_WIDTH-1:0] chkPC,
  output logic                  qEmpty
`ifdef BRQ_STAT_EN
  ,
  output logic [31:0]           statTotal,
  output logic [31:0]           statWrong
`endif
);

  localparam int ENTRY_W  = entry_width(ADDR_WIDTH);
  localparam int PDPC_LSB = pdpc_lsb(ADDR_WIDTH);
  localparam int PDBR     = pdbr_bit(ADDR_WIDTH);
  localparam int PDRSN    = pdrsn_bit(ADDR_WIDTH);

  logic [ENTRY_W-1:0]    entries [QUEUE_DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [PTR_WIDTH:0]    count;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ENTRY_W-1:0]    push_entry;
  logic                  wrong;
  logic [ADDR_WIDTH-1:0] correct_pc;
  logic                  check;
  logic                  mispredict;
  logic                  clear;
  logic                  do_push;
  logic                  do_pop;

  assign head_entry = entries[head];
  assign pushRdy    = (count < (PTR_WIDTH+1)'(QUEUE_DEPTH));
  assign qEmpty     = (count == '0);

  brq_checker #(.ADDR_WIDTH(ADDR_WIDTH)) u_checker (
    .pc         (head_entry[PC_LSB +: ADDR_WIDTH]),
    .pd_pc      (head_entry[PDPC_LSB +: ADDR_WIDTH]),
    .pd_branch  (head_entry[PDBR]),
    .pd_reason  (head_entry[PDRSN]),
    .ex_slot    (exSlot),
    .ex_branch  (exBranch),
    .ex_pc_tar  (exPCTar),
    .wrong      (wrong),
    .correct_pc (correct_pc)
  );

  // Qualify the check and derive this cycle's push/pop/clear decisions
  always_comb begin
    check      = exVld & ~qEmpty;
    mispredict = check & wrong & ~flush;
    clear      = flush | mispredict;
    do_push    = pushVld & pushRdy & ~clear;
    do_pop     = check & exLast & ~wrong & ~flush;
  end

  // Pack the incoming prediction into entry layout
  always_comb begin
    push_entry = '0;
    push_entry[PC_LSB +: ADDR_WIDTH]   = pushPC;
    push_entry[PDPC_LSB +: ADDR_WIDTH] = pushPdPC;
    push_entry[PDBR]                   = pushPdBranch;
    push_entry[PDRSN]                  = pushPdReason;
  end

  // Pointer and occupancy bookkeeping; a mispredict or flush empties the queue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count + (PTR_WIDTH+1)'(do_push) - (PTR_WIDTH+1)'(do_pop);
    end
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) entries[i] <= '0;
    end else if (do_push) begin
      entries[tail] <= push_entry;
    end
  end

  // Registered mispredict pulse; the redirect PC holds until the next one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chkWrong <= 1'b0;
      chkPC    <= '0;
    end else begin
      chkWrong <= mispredict;
      if (mispredict) chkPC <= correct_pc;
    end
  end

`ifdef BRQ_STAT_EN
  // Saturating counts of evaluated checks and signalled mispredicts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      statTotal <= '0;
      statWrong <= '0;
    end else begin
      if (check && (statTotal != '1))      statTotal <= statTotal + 1'b1;
      if (mispredict && (statWrong != '1)) statWrong <= statWrong + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_check_queue.sv
// Self-checking bench for branch_check_queue: a queue-based model of the
// prediction record is compared with the DUT after every clock edge, with
// directed scenarios pinned by hand-computed values and a randomized phase.
module tb_branch_check_queue;

  logic        clk;
  logic        rstn;
  logic        pushVld;
  logic        pushRdy;
  logic [31:0] pushPC;
  logic [31:0] pushPdPC;
  logic        pushPdBranch;
  logic        pushPdReason;
  logic        exVld;
  logic        exSlot;
  logic        exLast;
  logic        exBranch;
  logic [31:0] exPCTar;
  logic        flush;
  logic        chkWrong;
  logic [31:0] chkPC;
  logic        qEmpty;
`ifdef BRQ_STAT_EN
  logic [31:0] statTotal;
  logic [31:0] statWrong;
`endif

  branch_check_queue dut (
    .clk          (clk),
    .rstn         (rstn),
    .pushVld      (pushVld),
    .pushRdy      (pushRdy),
    .pushPC       (pushPC),
    .pushPdPC     (pushPdPC),
    .pushPdBranch (pushPdBranch),
    .pushPdReason (pushPdReason),
    .exVld        (exVld),
    .exSlot       (exSlot),
    .exLast       (exLast),
    .exBranch     (exBranch),
    .exPCTar      (exPCTar),
    .flush        (flush),
    .chkWrong     (chkWrong),
    .chkPC        (chkPC),
    .qEmpty       (qEmpty)
`ifdef BRQ_STAT_EN
    ,
    .statTotal    (statTotal),
    .statWrong    (statWrong)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pdpc;
    logic        br;
    logic        rsn;
  } ent_t;

  ent_t        mq[$];
  logic        exp_wrong;
  logic [31:0] exp_pc;
  bit          check_en;
  int          n_cmp;
  int          n_bad;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs after each edge against the model's predicted state
  always @(posedge clk) begin
    #1;
    if (check_en && rstn) begin
      checkOutput("chkWrong", {31'b0, chkWrong}, {31'b0, exp_wrong});
      checkOutput("chkPC", chkPC, exp_pc);
      checkOutput("qEmpty", {31'b0, qEmpty}, {31'b0, (mq.size() == 0)});
      checkOutput("pushRdy", {31'b0, pushRdy}, {31'b0, (mq.size() < 8)});
    end
  end

  // Apply this cycle's inputs to the model: what the queue must hold after the edge
  task automatic modelStep();
    bit          chk;
    bit          w;
    bit          room;
    logic [31:0] cpc;
    ent_t        h;
    ent_t        e;
    chk  = exVld && (mq.size() > 0);
    room = (mq.size() < 8);
    w    = 0;
    cpc  = 0;
    if (chk) begin
      h = mq[0];
      if (!h.br)                 w = exBranch;
      else if (h.rsn == exSlot)  w = !exBranch || (exPCTar != h.pdpc);
      else                       w = exBranch;
      cpc = exBranch ? exPCTar : h.pc + 32'(exSlot) * 4 + 4;
    end
    if (flush) begin
      mq.delete();
      exp_wrong = 0;
    end else if (chk && w) begin
      mq.delete();
      exp_wrong = 1;
      exp_pc    = cpc;
    end else begin
      exp_wrong = 0;
      if (chk && exLast) void'(mq.pop_front());
      if (pushVld && room) begin
        e.pc = pushPC; e.pdpc = pushPdPC; e.br = pushPdBranch; e.rsn = pushPdReason;
        mq.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic [31:0] ppd,
                               input logic pbr, input logic prsn, input logic ev, input logic es,
                               input logic el, input logic eb, input logic [31:0] etar,
                               input logic fl);
    @(negedge clk);
    pushVld = pv; pushPC = ppc; pushPdPC = ppd; pushPdBranch = pbr; pushPdReason = prsn;
    exVld = ev; exSlot = es; exLast = el; exBranch = eb; exPCTar = etar; flush = fl;
    modelStep();
    check_en = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pushOnly(input logic [31:0] ppc, input logic [31:0] ppd, input logic pbr, input logic prsn);
    applyStimulus(1, ppc, ppd, pbr, prsn, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exOnly(input logic es, input logic el, input logic eb, input logic [31:0] etar);
    applyStimulus(0, 0, 0, 0, 0, 1, es, el, eb, etar, 0);
  endtask

  task automatic clearInputs();
    pushVld = 0; pushPC = 0; pushPdPC = 0; pushPdBranch = 0; pushPdReason = 0;
    exVld = 0; exSlot = 0; exLast = 0; exBranch = 0; exPCTar = 0; flush = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        rs;
    logic        rbr;
    logic [31:0] tar;
    n_cmp = 0; n_bad = 0; check_en = 0;
    exp_wrong = 0; exp_pc = 0;
    clearInputs();
    rstn = 0;
    #12;
    checkOutput("reset_qEmpty", {31'b0, qEmpty}, 32'd1);
    checkOutput("reset_pushRdy", {31'b0, pushRdy}, 32'd1);
    checkOutput("reset_chkWrong", {31'b0, chkWrong}, 32'd0);
    checkOutput("reset_chkPC", chkPC, 32'h0);
    @(negedge clk);
    rstn = 1;

    $display("[TB] scenario: correctly predicted fall-through pair");
    pushOnly(32'h1000, 32'h1008, 0, 0);
    exOnly(0, 0, 0, 0);
    exOnly(1, 1, 0, 0);
    checkOutput("s1_chkWrong", {31'b0, chkWrong}, 32'd0);
    checkOutput("s1_qEmpty", {31'b0, qEmpty}, 32'd1);

    $display("[TB] scenario: predicted-taken slot1 with wrong target");
    pushOnly(32'h1000, 32'h2000, 1, 1);
    exOnly(1, 1, 1, 32'h2400);
    checkOutput("s2_chkWrong", {31'b0, chkWrong}, 32'd1);
    checkOutput("s2_chkPC", chkPC, 32'h2400);
    checkOutput("s2_qEmpty", {31'b0, qEmpty}, 32'd1);
    idle();
    checkOutput("s2_pulse", {31'b0, chkWrong}, 32'd0);
    checkOutput("s2_hold", chkPC, 32'h2400);

    $display("[TB] scenario: predicted-taken slot1 not taken");
    pushOnly(32'h1000, 32'h2000, 1, 1);
    exOnly(0, 0, 0, 0);
    checkOutput("s3_slot0", {31'b0, chkWrong}, 32'd0);
    exOnly(1, 1, 0, 0);
    checkOutput("s3_chkWrong", {31'b0, chkWrong}, 32'd1);
    checkOutput("s3_chkPC", chkPC, 32'h1008);

    $display("[TB] scenario: full queue, pop does not free a push slot, tail wraps");
    for (int i = 0; i < 8; i++) pushOnly(32'h100 * i, 0, 0, 0);
    checkOutput("s4_full", {31'b0, pushRdy}, 32'd0);
    applyStimulus(1, 32'h9000, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    checkOutput("s4_after_pop", {31'b0, pushRdy}, 32'd1);
    pushOnly(32'h3000, 32'h7000, 1, 1);
    checkOutput("s4_refull", {31'b0, pushRdy}, 32'd0);
    for (int i = 0; i < 7; i++) exOnly(1, 1, 0, 0);
    checkOutput("s4_drained7", {31'b0, chkWrong}, 32'd0);
    exOnly(1, 1, 0, 0);
    checkOutput("s4_wrap_wrong", {31'b0, chkWrong}, 32'd1);
    checkOutput("s4_wrap_pc", chkPC, 32'h3008);

    $display("[TB] scenario: flush beats mispredict and push");
    for (int i = 0; i < 3; i++) pushOnly(32'h4000 + 32'h8 * i, 0, 0, 0);
    applyStimulus(1, 32'h5000, 0, 0, 0, 1, 0, 1, 1, 32'h6000, 1);
    checkOutput("s5_chkWrong", {31'b0, chkWrong}, 32'd0);
    checkOutput("s5_qEmpty", {31'b0, qEmpty}, 32'd1);
    checkOutput("s5_chkPC_kept", chkPC, 32'h3008);
    idle();
    checkOutput("s5_push_dropped", {31'b0, qEmpty}, 32'd1);

    $display("[TB] randomized phase");
    for (int n = 0; n < 400; n++) begin
      rbr = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      tar = {$urandom_range(0, 32'hFFFF), 3'b000} & 32'h000F_FFF8;
      if (mq.size() > 0) begin
        if (mq[0].br && !mq[0].rsn) rs = 0;
        if ($urandom_range(0, 1) == 1) tar = mq[0].pdpc;
      end
      applyStimulus(($urandom_range(0, 9) < 7),
                    $urandom_range(0, 32'hFFFF) << 3,
                    $urandom_range(0, 32'hFFFF) << 3,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1),
                    rs,
                    rs ? 1'b1 : ($urandom_range(0, 9) < 3),
                    rbr,
                    tar,
                    ($urandom_range(0, 99) < 3));
    end
    idle();

    $display("[TB] scenario: asynchronous reset mid-stream");
    for (int i = 0; i < 5; i++) pushOnly(32'h8000 + 32'h8 * i, 0, 0, 0);
    @(negedge clk);
    #1;
    check_en = 0;
    rstn = 0;
    #1;
    checkOutput("rst_qEmpty", {31'b0, qEmpty}, 32'd1);
    checkOutput("rst_chkWrong", {31'b0, chkWrong}, 32'd0);
    checkOutput("rst_chkPC", chkPC, 32'h0);
    checkOutput("rst_pushRdy", {31'b0, pushRdy}, 32'd1);
    mq.delete();
    exp_wrong = 0;
    exp_pc    = 0;
    clearInputs();
    @(negedge clk);
    rstn = 1;
    idle();
    checkOutput("rst_stays_empty", {31'b0, qEmpty}, 32'd1);

`ifdef BRQ_STAT_EN
    checkOutput("stat_total_reset", statTotal, 32'd0);
    checkOutput("stat_wrong_reset", statWrong, 32'd0);
    pushOnly(32'h1000, 0, 0, 0);
    pushOnly(32'h1008, 0, 0, 0);
    exOnly(0, 0, 0, 0);
    exOnly(1, 1, 0, 0);
    exOnly(0, 0, 1, 32'h2000);
    checkOutput("stat_total", statTotal, 32'd3);
    checkOutput("stat_wrong", statWrong, 32'd1);
`endif

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
